// File: rtl/main_fsm.sv
// Multicycle control FSM for the fetch/decode/execute/writeback datapath.
// Wait states (FETCH, MEMRD, MEMWR) abort back to FETCH after TIMEOUT stalled cycles.
module main_fsm #(
    parameter int TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] i_op,
    input  logic [5:0] i_funct,
    input  logic       i_mem_ready,
    output logic       o_ir_write,
    output logic       o_adr_src,
    output logic [1:0] o_alu_src_a,
    output logic [1:0] o_alu_src_b,
    output logic [1:0] o_result_src,
    output logic       o_next_pc,
    output logic       o_reg_w,
    output logic       o_mem_w,
    output logic       o_branch,
    output logic       o_alu_op,
    output logic       o_mem_timeout,
    output logic [3:0] o_state
);

    localparam int              CW      = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0]   CNT_MAX = CW'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [CW-1:0]   r_stall_cnt;
    logic [CW-1:0]   w_stall_cnt_next;
    logic            r_timeout;
    logic            w_wait;
    logic            w_abort;

    logic            w_ir_write;
    logic            w_next_pc;
    logic            w_reg_w;
    logic            w_mem_w;
    logic            w_branch;
    logic            w_unused_funct;

    assign w_unused_funct = ^i_funct[4:1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_FETCH;
            r_stall_cnt <= '0;
            r_timeout   <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_stall_cnt <= w_stall_cnt_next;
            r_timeout   <= w_abort;
        end
    end

    // The counter only survives while a wait state keeps stalling; any exit clears it.
    always_comb begin
        w_wait  = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
        w_abort = w_wait && !i_mem_ready && (r_stall_cnt == CNT_MAX);

        w_stall_cnt_next = '0;
        if (w_wait && !i_mem_ready && !w_abort)
            w_stall_cnt_next = r_stall_cnt + 1'b1;

        w_state_next = S_FETCH;
        case (r_state)
            S_FETCH:    w_state_next = i_mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (i_op)
                    2'b00:   w_state_next = i_funct[5] ? S_EXECUTEI : S_EXECUTER;
                    2'b01:   w_state_next = S_MEMADR;
                    2'b10:   w_state_next = S_BRANCH;
                    default: w_state_next = S_FETCH;
                endcase
            end
            S_MEMADR:   w_state_next = i_funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD: begin
                if (i_mem_ready)
                    w_state_next = S_MEMWB;
                else if (w_abort)
                    w_state_next = S_FETCH;
                else
                    w_state_next = S_MEMRD;
            end
            S_MEMWR:    w_state_next = (i_mem_ready || w_abort) ? S_FETCH : S_MEMWR;
            S_EXECUTER: w_state_next = S_ALUWB;
            S_EXECUTEI: w_state_next = S_ALUWB;
            default:    w_state_next = S_FETCH;
        endcase
    end

    always_comb begin
        w_ir_write   = 1'b0;
        w_next_pc    = 1'b0;
        w_reg_w      = 1'b0;
        w_mem_w      = 1'b0;
        w_branch     = 1'b0;
        o_adr_src    = 1'b0;
        o_alu_src_a  = 2'b00;
        o_alu_src_b  = 2'b00;
        o_result_src = 2'b00;
        o_alu_op     = 1'b0;
        case (r_state)
            S_FETCH: begin
                o_alu_src_a  = 2'b01;
                o_alu_src_b  = 2'b10;
                o_result_src = 2'b10;
                w_ir_write   = i_mem_ready;
                w_next_pc    = i_mem_ready;
            end
            S_DECODE: begin
                o_alu_src_a  = 2'b01;
                o_alu_src_b  = 2'b10;
                o_result_src = 2'b10;
            end
            S_MEMADR:   o_alu_src_b = 2'b01;
            S_MEMRD:    o_adr_src   = 1'b1;
            S_MEMWB: begin
                o_result_src = 2'b01;
                w_reg_w      = 1'b1;
            end
            S_MEMWR: begin
                o_adr_src = 1'b1;
                w_mem_w   = 1'b1;
            end
            S_EXECUTER: o_alu_op = 1'b1;
            S_EXECUTEI: begin
                o_alu_src_b = 2'b01;
                o_alu_op    = 1'b1;
            end
            S_ALUWB:    w_reg_w = 1'b1;
            S_BRANCH: begin
                o_alu_src_b  = 2'b01;
                o_result_src = 2'b10;
                w_branch     = 1'b1;
            end
            default: ;
        endcase
    end

    // Write-type requests are held off for the whole reset interval, not just until the next edge.
    assign o_ir_write    = w_ir_write & rst_n;
    assign o_next_pc     = w_next_pc  & rst_n;
    assign o_reg_w       = w_reg_w    & rst_n;
    assign o_mem_w       = w_mem_w    & rst_n;
    assign o_branch      = w_branch   & rst_n;
    assign o_mem_timeout = r_timeout;
    assign o_state       = r_state;

endmodule

// File: tb/tb_main_fsm.sv
// Scoreboard bench for main_fsm: each driven cycle pushes its expected state/outputs,
// a negedge monitor pops and compares them.
module tb_main_fsm;

    logic       clk;
    logic       rst_n;
    logic [1:0] i_op;
    logic [5:0] i_funct;
    logic       i_mem_ready;
    logic       o_ir_write;
    logic       o_adr_src;
    logic [1:0] o_alu_src_a;
    logic [1:0] o_alu_src_b;
    logic [1:0] o_result_src;
    logic       o_next_pc;
    logic       o_reg_w;
    logic       o_mem_w;
    logic       o_branch;
    logic       o_alu_op;
    logic       o_mem_timeout;
    logic [3:0] o_state;

    int total_cnt = 0;
    int bad_cnt   = 0;

    logic [17:0] sb_q[$];
    string       tag_q[$];

    main_fsm #(.TIMEOUT(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_op          (i_op),
        .i_funct       (i_funct),
        .i_mem_ready   (i_mem_ready),
        .o_ir_write    (o_ir_write),
        .o_adr_src     (o_adr_src),
        .o_alu_src_a   (o_alu_src_a),
        .o_alu_src_b   (o_alu_src_b),
        .o_result_src  (o_result_src),
        .o_next_pc     (o_next_pc),
        .o_reg_w       (o_reg_w),
        .o_mem_w       (o_mem_w),
        .o_branch      (o_branch),
        .o_alu_op      (o_alu_op),
        .o_mem_timeout (o_mem_timeout),
        .o_state       (o_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [13:0] w_obs;
    assign w_obs = {o_ir_write, o_adr_src, o_alu_src_a, o_alu_src_b, o_result_src,
                    o_next_pc, o_reg_w, o_mem_w, o_branch, o_alu_op, o_mem_timeout};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Expected decode of each state, straight from the output table.
    function automatic logic [13:0] exp_outs(input logic [3:0] st, input logic rdy, input logic tmo);
        logic       ir, adr, npc, regw, memw, br, aluop;
        logic [1:0] srca, srcb, res;
        ir = 0; adr = 0; npc = 0; regw = 0; memw = 0; br = 0; aluop = 0;
        srca = 2'b00; srcb = 2'b00; res = 2'b00;
        case (st)
            4'd0: begin srca = 2'b01; srcb = 2'b10; res = 2'b10; ir = rdy; npc = rdy; end
            4'd1: begin srca = 2'b01; srcb = 2'b10; res = 2'b10; end
            4'd2: srcb = 2'b01;
            4'd3: adr = 1;
            4'd4: begin res = 2'b01; regw = 1; end
            4'd5: begin adr = 1; memw = 1; end
            4'd6: aluop = 1;
            4'd7: begin srcb = 2'b01; aluop = 1; end
            4'd8: regw = 1;
            4'd9: begin srcb = 2'b01; res = 2'b10; br = 1; end
            default: ;
        endcase
        return {ir, adr, srca, srcb, res, npc, regw, memw, br, aluop, tmo};
    endfunction

    task automatic step(input string tag, input logic [3:0] st, input logic [1:0] op,
                        input logic [5:0] funct, input logic rdy, input logic tmo);
        i_op        = op;
        i_funct     = funct;
        i_mem_ready = rdy;
        sb_q.push_back({st, exp_outs(st, rdy, tmo)});
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            logic [17:0] e;
            string       t;
            e = sb_q.pop_front();
            t = tag_q.pop_front();
            $display("%s: state=%0d outs=%04h (exp state=%0d outs=%04h)", t, o_state, w_obs, e[17:14], e[13:0]);
            check_eq({t, "_state"}, 32'(o_state), 32'(e[17:14]));
            check_eq({t, "_outs"},  32'(w_obs),   32'(e[13:0]));
        end
    end

    localparam logic [5:0] F_ADDR = 6'b001000;
    localparam logic [5:0] F_ADDI = 6'b101000;
    localparam logic [5:0] F_LDR  = 6'b011001;
    localparam logic [5:0] F_STR  = 6'b011000;

    initial begin
        rst_n = 1'b0; i_op = 2'b00; i_funct = 6'd0; i_mem_ready = 1'b1;
        #3;
        check_eq("rst_state", 32'(o_state), 32'd0);
        check_eq("rst_outs",  32'(w_obs),   32'(exp_outs(4'd0, 1'b0, 1'b0)));
        @(posedge clk); #1;
        rst_n = 1'b1;

        // ADD reg, ADD imm
        step("add_r", 0, 2'b00, F_ADDR, 1, 0);
        step("add_r", 1, 2'b00, F_ADDR, 1, 0);
        step("add_r", 6, 2'b00, F_ADDR, 1, 0);
        step("add_r", 8, 2'b00, F_ADDR, 1, 0);
        step("add_i", 0, 2'b00, F_ADDI, 1, 0);
        step("add_i", 1, 2'b00, F_ADDI, 1, 0);
        step("add_i", 7, 2'b00, F_ADDI, 1, 0);
        step("add_i", 8, 2'b00, F_ADDI, 1, 0);
        // LDR
        step("ldr", 0, 2'b01, F_LDR, 1, 0);
        step("ldr", 1, 2'b01, F_LDR, 1, 0);
        step("ldr", 2, 2'b01, F_LDR, 1, 0);
        step("ldr", 3, 2'b01, F_LDR, 1, 0);
        step("ldr", 4, 2'b01, F_LDR, 1, 0);
        // STR, 3 stalls then ready exactly at the limit count
        step("str", 0, 2'b01, F_STR, 1, 0);
        step("str", 1, 2'b01, F_STR, 1, 0);
        step("str", 2, 2'b01, F_STR, 1, 0);
        for (int i = 0; i < 3; i++) step("str_wait", 5, 2'b01, F_STR, 0, 0);
        step("str", 5, 2'b01, F_STR, 1, 0);
        // B, then undefined
        step("b", 0, 2'b10, 6'd0, 1, 0);
        step("b", 1, 2'b10, 6'd0, 1, 0);
        step("b", 9, 2'b10, 6'd0, 1, 0);
        step("und", 0, 2'b11, 6'd0, 1, 0);
        step("und", 1, 2'b11, 6'd0, 1, 0);
        // FETCH timeout, retry, then ready at the limit count
        for (int i = 0; i < 4; i++) step("fto_wait", 0, 2'b11, 6'd0, 0, 0);
        step("fto_abort", 0, 2'b11, 6'd0, 0, 1);
        step("fto_wait", 0, 2'b11, 6'd0, 0, 0);
        step("fto_wait", 0, 2'b11, 6'd0, 0, 0);
        step("fto_ready", 0, 2'b11, 6'd0, 1, 0);
        step("fto_dec", 1, 2'b11, 6'd0, 1, 0);
        // MEMRD timeout: no writeback
        step("rto", 0, 2'b01, F_LDR, 1, 0);
        step("rto", 1, 2'b01, F_LDR, 1, 0);
        step("rto", 2, 2'b01, F_LDR, 1, 0);
        for (int i = 0; i < 4; i++) step("rto_wait", 3, 2'b01, F_LDR, 0, 0);
        step("rto_abort", 0, 2'b11, 6'd0, 1, 1);
        step("rto_dec", 1, 2'b11, 6'd0, 1, 0);
        // Asynchronous reset in the middle of MEMRD
        step("rst6", 0, 2'b01, F_LDR, 1, 0);
        step("rst6", 1, 2'b01, F_LDR, 1, 0);
        step("rst6", 2, 2'b01, F_LDR, 1, 0);
        i_mem_ready = 1'b0;
        #2;
        check_eq("rst6_pre_state", 32'(o_state), 32'd3);
        i_mem_ready = 1'b1;
        rst_n = 1'b0;
        #1;
        check_eq("rst6_state", 32'(o_state), 32'd0);
        check_eq("rst6_outs",  32'(w_obs),   32'(exp_outs(4'd0, 1'b0, 1'b0)));
        @(posedge clk); #1;
        check_eq("rst6_hold_state", 32'(o_state), 32'd0);
        check_eq("rst6_hold_ir",    32'(o_ir_write), 32'd0);
        rst_n = 1'b1;
        step("post", 0, 2'b00, F_ADDR, 1, 0);
        step("post", 1, 2'b00, F_ADDR, 1, 0);
        step("post", 6, 2'b00, F_ADDR, 1, 0);
        step("post", 8, 2'b00, F_ADDR, 1, 0);
        step("post", 0, 2'b11, 6'd0, 0, 0);
        check_eq("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
